// File: rtl/sniffer_pkg.sv
// Shared definitions for the data sniffer pipeline: ASCII constants and the
// number token parser state encoding.
package sniffer_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SIGN  = 2'd2
  } parser_state_t;

endpackage

// File: rtl/digit_accum.sv
// Combinational decimal multiply-accumulate step: acc*10 + digit, clamped to
// all ones with a sticky overflow flag once the result no longer fits.
module digit_accum #(
  parameter int VALUE_W = 32
) (
  input  logic [VALUE_W-1:0] acc,
  input  logic [3:0]         digit,
  input  logic               overflow_in,
  output logic [VALUE_W-1:0] next_acc,
  output logic               overflow_out
);

  localparam int WIDE_W = VALUE_W + 4;

  logic [WIDE_W-1:0] wide_acc;
  logic [WIDE_W-1:0] product;

  // Four guard bits always hold acc*10+9, so the carry-out test is exact.
  assign wide_acc     = WIDE_W'(acc);
  assign product      = (wide_acc << 3) + (wide_acc << 1) + WIDE_W'(digit);
  assign overflow_out = overflow_in | (|product[WIDE_W-1:VALUE_W]);
  assign next_acc     = overflow_out ? '1 : product[VALUE_W-1:0];

endmodule

// File: rtl/number_token_parser.sv
// Groups consecutive ASCII digits into tokens and emits their binary value.
// Optional signed-token support is enabled by defining NUMBER_TOKEN_SIGN_EN.
module number_token_parser
  import sniffer_pkg::*;
#(
  parameter int VALUE_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [7:0]         data_in,
  input  logic               is_number_in,
  input  logic               is_white_in,
  input  logic               flush_in,
  output logic [VALUE_W-1:0] value_out,
  output logic               negative_out,
  output logic               overflow_out,
  output logic [4:0]         digits_out,
  output logic               valid_out,
  output logic [CNT_W-1:0]   token_count_out
);

  parser_state_t      state, state_n;
  logic [VALUE_W-1:0] acc, acc_n, mac_acc, emit_acc;
  logic [4:0]         digits, digits_n, digits_inc, emit_digits;
  logic               ovf, ovf_n, mac_ovf, emit_ovf, emit;
  logic [3:0]         digit;
  logic               is_digit;
  logic               unused_white;

  // Any non-digit terminates a token, so the whitespace flag carries no weight.
  assign unused_white = is_white_in;
  assign digit        = 4'(data_in - ASCII_ZERO);
  assign is_digit     = enable & is_number_in;
  assign digits_inc   = (digits == 5'd31) ? digits : digits + 5'd1;

`ifdef NUMBER_TOKEN_SIGN_EN
  logic neg, neg_n, emit_neg, is_minus;
  assign is_minus = enable & (data_in == ASCII_MINUS);
`endif

  digit_accum #(.VALUE_W(VALUE_W)) u_digit_accum (
    .acc          (acc),
    .digit        (digit),
    .overflow_in  (ovf),
    .next_acc     (mac_acc),
    .overflow_out (mac_ovf)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n     = state;
    acc_n       = acc;
    digits_n    = digits;
    ovf_n       = ovf;
    emit        = 1'b0;
    emit_acc    = acc;
    emit_digits = digits;
    emit_ovf    = ovf;
`ifdef NUMBER_TOKEN_SIGN_EN
    neg_n       = neg;
    emit_neg    = neg;
`endif
    case (state)
      IDLE: begin
        if (is_digit) begin
          state_n  = ACCUM;
          acc_n    = VALUE_W'(digit);
          digits_n = 5'd1;
          ovf_n    = 1'b0;
`ifdef NUMBER_TOKEN_SIGN_EN
          neg_n    = 1'b0;
        end else if (is_minus) begin
          state_n  = SIGN;
`endif
        end
      end
      ACCUM: begin
        if (is_digit) begin
          acc_n    = mac_acc;
          ovf_n    = mac_ovf;
          digits_n = digits_inc;
        end
        // A digit arriving with flush is folded in above before the token closes.
        if (flush_in || (enable && !is_number_in)) begin
          emit        = 1'b1;
          emit_acc    = acc_n;
          emit_digits = digits_n;
          emit_ovf    = ovf_n;
          state_n     = IDLE;
          acc_n       = '0;
          digits_n    = '0;
          ovf_n       = 1'b0;
`ifdef NUMBER_TOKEN_SIGN_EN
          neg_n       = 1'b0;
          if (is_minus && !flush_in) state_n = SIGN;
`endif
        end
      end
`ifdef NUMBER_TOKEN_SIGN_EN
      SIGN: begin
        if (flush_in) begin
          state_n = IDLE;
        end else if (is_digit) begin
          state_n  = ACCUM;
          acc_n    = VALUE_W'(digit);
          digits_n = 5'd1;
          ovf_n    = 1'b0;
          neg_n    = 1'b1;
        end else if (enable && !is_minus) begin
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      acc             <= '0;
      digits          <= '0;
      ovf             <= 1'b0;
      value_out       <= '0;
      overflow_out    <= 1'b0;
      digits_out      <= '0;
      valid_out       <= 1'b0;
      token_count_out <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      digits    <= digits_n;
      ovf       <= ovf_n;
      valid_out <= emit;
      if (emit) begin
        value_out    <= emit_acc;
        overflow_out <= emit_ovf;
        digits_out   <= emit_digits;
        if (token_count_out != '1) token_count_out <= token_count_out + CNT_W'(1);
      end
    end
  end

`ifdef NUMBER_TOKEN_SIGN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      neg          <= 1'b0;
      negative_out <= 1'b0;
    end else begin
      neg <= neg_n;
      if (emit) negative_out <= emit_neg;
    end
  end
`else
  assign negative_out = 1'b0;
`endif

endmodule

// File: tb/tb_number_token_parser.sv
// Directed bench for number_token_parser with an expected-token scoreboard;
// sign-dependent expectations follow NUMBER_TOKEN_SIGN_EN.
module tb_number_token_parser;
  import sniffer_pkg::*;

`ifdef NUMBER_TOKEN_SIGN_EN
  localparam logic SIGN_ON = 1'b1;
`else
  localparam logic SIGN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        is_number_in = 1'b0;
  logic        is_white_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [31:0] value_out;
  logic        negative_out;
  logic        overflow_out;
  logic [4:0]  digits_out;
  logic        valid_out;
  logic [15:0] token_count_out;

  typedef struct {
    logic [31:0] value;
    logic        ovf;
    logic [4:0]  digits;
    logic        neg;
    logic [15:0] count;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_count = '0;
  int          errors = 0;
  int          checks = 0;

  number_token_parser #(.VALUE_W(32), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .data_in         (data_in),
    .is_number_in    (is_number_in),
    .is_white_in     (is_white_in),
    .flush_in        (flush_in),
    .value_out       (value_out),
    .negative_out    (negative_out),
    .overflow_out    (overflow_out),
    .digits_out      (digits_out),
    .valid_out       (valid_out),
    .token_count_out (token_count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v, input logic o, input logic [4:0] d, input logic n);
    exp_t e;
    exp_count++;
    e.value = v; e.ovf = o; e.digits = d; e.neg = n; e.count = exp_count;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fl = 1'b0);
    data_in      = b;
    is_number_in = (b >= 8'h30) && (b <= 8'h39);
    is_white_in  = (b == 8'h20);
    enable       = 1'b1;
    flush_in     = fl;
    @(posedge clk); #1;
    enable   = 1'b0;
    flush_in = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard: each valid pulse is matched against the oldest expected token.
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", valid_out, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tok_value",  value_out,       e.value);
        check("tok_ovf",    overflow_out,    e.ovf);
        check("tok_digits", digits_out,      e.digits);
        check("tok_neg",    negative_out,    e.neg);
        check("tok_count",  token_count_out, e.count);
      end
    end
  end

  initial begin
    // Reset state
    idle(2);
    check("rst_value",  value_out,       32'd0);
    check("rst_valid",  valid_out,       1'b0);
    check("rst_digits", digits_out,      5'd0);
    check("rst_ovf",    overflow_out,    1'b0);
    check("rst_neg",    negative_out,    1'b0);
    check("rst_count",  token_count_out, 16'd0);
    rst = 1'b0;
    idle(1);

    // Mixed stream; '-' closes 20 and the result appears right after it
    push(32'd2, 1'b0, 5'd1, 1'b0);
    push(32'd1, 1'b0, 5'd1, 1'b0);
    push(32'd3, 1'b0, 5'd1, 1'b0);
    push(32'd20, 1'b0, 5'd2, 1'b0);
    push(32'd2540, 1'b0, 5'd5, SIGN_ON);
    send_str("pp2p 1h3c  traas20");
    send_byte("-");
    check("minus_latency_valid", valid_out, 1'b1);
    check("minus_latency_value", value_out, 32'd20);
    send_str("02540kkkk");
    idle(2);
    check("stream1_count", token_count_out, 16'd5);

    // Overflow boundary at 2^32-1
    push(32'hFFFF_FFFF, 1'b0, 5'd10, 1'b0);
    push(32'hFFFF_FFFF, 1'b1, 5'd10, 1'b0);
    send_str("4294967295 4294967296 ");
    idle(2);

    // Enable gap, then digit together with flush
    push(32'd123, 1'b0, 5'd3, 1'b0);
    send_str("12");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("gap_no_valid", valid_out, 1'b0);
    end
    send_byte("3", 1'b1);
    check("flush_valid", valid_out, 1'b1);
    check("flush_value", value_out, 32'd123);
    flush_in = 1'b1;
    idle(2);
    flush_in = 1'b0;
    check("flush_idle_count", token_count_out, 16'd8);

    // Leading zeros and digit-count saturation
    push(32'd7, 1'b0, 5'd3, 1'b0);
    send_str("007 ");
    push(32'd1, 1'b0, 5'd31, 1'b0);
    for (int i = 0; i < 33; i++) send_byte("0");
    send_str("1 ");
    idle(2);
    check("sat_count", token_count_out, 16'd10);

    // Reset mid-token discards it and clears the count
    send_str("98");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_count", token_count_out, 16'd0);
    check("midrst_value", value_out, 32'd0);
    exp_count = '0;
    push(32'd5, 1'b0, 5'd1, 1'b0);
    send_str(" 5 ");
    idle(1);
    check("post_rst_count", token_count_out, 16'd1);

    // Sign handling (negative only when the feature is built in)
    push(32'd5, 1'b0, 5'd1, SIGN_ON);
    send_str("-5 ");
    push(32'd3, 1'b0, 5'd1, 1'b0);
    push(32'd4, 1'b0, 5'd1, SIGN_ON);
    send_str("3-4 ");
    send_str("x-");
    check("sign_state", dut.state, SIGN_ON ? SIGN : IDLE);
    send_byte(" ");
    check("sign_exit_state", dut.state, IDLE);
    idle(2);
    check("final_count", token_count_out, 16'd4);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/number_token_parser.md
Name: number_token_parser

Overview:
- Downstream of the character shift register in the data sniffer pipeline.
- Consumes the oldest byte of the window, one per enabled cycle, together with its is_number/is_white flags.
- Groups consecutive ASCII decimal digits into tokens and converts each token to an unsigned binary value.
- Emits one result per completed token with valid, overflow and digit-count qualifiers, and keeps a running token count.

Parameters:
- VALUE_W, 32, width of the converted value.
- CNT_W, 16, width of the saturating token counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  byte strobe; one byte is consumed per cycle while high.
- data_in  input  8  ASCII byte from the shift register tail.
- is_number_in  input  1  data_in is '0'..'9'.
- is_white_in  input  1  data_in is whitespace (informational only; any non-digit terminates).
- flush_in  input  1  end of stream; terminates any open token.
- value_out  output  VALUE_W  converted token value.
- negative_out  output  1  token carried a leading '-' (only with the optional feature).
- overflow_out  output  1  token value exceeded 2^VALUE_W-1.
- digits_out  output  5  number of digits in the token, saturating at 31.
- valid_out  output  1  one-cycle result strobe.
- token_count_out  output  CNT_W  tokens emitted since reset, saturating.

Behaviour:
- Reset: every output is 0, state is IDLE, and the accumulator and digit counter are 0.
- FSM states: IDLE, ACCUM, SIGN (SIGN exists only with the optional feature).
- A byte is consumed only when enable=1. With enable=0 the state and accumulator hold and valid_out is 0.
- IDLE + digit: go to ACCUM. Accumulator = digit, digits = 1, overflow flag = 0.
- IDLE + non-digit: stay in IDLE with no output.
- ACCUM + digit: acc = acc*10 + (data_in-8'h30).
  - Compute at VALUE_W+4 bits.
  - If the result exceeds VALUE_W bits, set the sticky overflow flag and clamp acc to all ones.
  - Once overflowed, acc stays at all ones until the token ends.
  - digits increments, saturating at 31.
- ACCUM + non-digit (the terminator):
  - On the next edge, register value_out, overflow_out, digits_out and negative_out, and pulse valid_out=1 for exactly one cycle.
  - token_count increments, saturating at all ones.
  - The state returns to IDLE; the terminator byte is consumed.
- Latency: valid_out is high in the cycle after the terminator byte is sampled.
- Result outputs hold their last values until the next valid_out; only valid_out is a pulse.
- flush_in=1 in ACCUM: acts as a terminator, whether or not enable is high and regardless of data_in.
- flush_in=1 in IDLE: no effect.
- flush_in=1 together with an enabled digit: the digit is accumulated first, then the token is emitted including that digit.
- Leading zeros are accepted and counted in digits ("007" gives value 7, digits 3).
- rst mid-token: the token is discarded, no valid_out is produced, and token_count clears.

Optional Feature:
- Macro: NUMBER_TOKEN_SIGN_EN.
- Defined:
  - IDLE + '-' (8'h2D) goes to SIGN.
  - SIGN + digit goes to ACCUM with the negative flag set.
  - SIGN + '-' stays in SIGN.
  - SIGN + any other byte, or flush_in, returns to IDLE with no output.
  - ACCUM + '-' emits the current token (negative as latched) and then enters SIGN in the same edge.
  - value_out stays the unsigned magnitude; negative_out qualifies it.
- Undefined:
  - The SIGN state and sign logic are absent.
  - '-' is an ordinary terminator.
  - negative_out is tied to 0.

Decomposition:
- Shared package sniffer_pkg holds:
  - the ASCII constants (ASCII_ZERO 8'h30, ASCII_MINUS 8'h2D);
  - the typedef parser_state_t {IDLE, ACCUM, SIGN}.
- One sub-module, digit_accum (combinational):
  - inputs: acc, digit, overflow_in;
  - outputs: next_acc, overflow_out;
  - implements (acc<<3)+(acc<<1)+digit with clamp.

Test Plan:
- Reset, then stream "pp2p 1h3c  traas20-02540kkkk" with enable=1, feature off:
  - valid pulses with values 2, 1, 3, 20, 2540;
  - digits 1, 1, 1, 2, 5;
  - token_count ends at 5.
- Same stream with NUMBER_TOKEN_SIGN_EN defined:
  - values 2, 1, 3, 20, 2540;
  - negative_out=1 only on the 2540 token;
  - 20 is emitted in the cycle after '-' is sampled.
- VALUE_W=32, stream "4294967295 " then "4294967296 ":
  - first token: value 32'hFFFFFFFF, overflow 0, digits 10;
  - second token: value 32'hFFFFFFFF, overflow 1.
- Stream "12", drop enable for 3 cycles, then "3" followed by flush_in:
  - no valid during the gap;
  - a single valid with value 123, digits 3.
- Stream "98", assert rst for 1 cycle, then " 5 ":
  - no result for 98;
  - value 5, token_count 1.
- Stream "x-" then " " with the feature on:
  - no valid_out;
  - FSM visits SIGN and returns to IDLE.
